// File: rtl/rv_defs.sv
// rtl/rv_defs.sv - uRV shared opcode constants, immediate formats and decode record
package rv_defs;

    // Major opcodes, instruction bits [6:2]
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    // fun7 of the M-extension multiply/divide group under OPC_OP
    localparam logic [6:0] FUN7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Immediate layout used by each major opcode; OP and unknown opcodes carry none
    function automatic imm_fmt_e imm_fmt_of(input logic [4:0] opc);
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: imm_fmt_of = IMM_I;
            OPC_STORE:                                  imm_fmt_of = IMM_S;
            OPC_BRANCH:                                 imm_fmt_of = IMM_B;
            OPC_LUI, OPC_AUIPC:                         imm_fmt_of = IMM_U;
            OPC_JAL:                                    imm_fmt_of = IMM_J;
            default:                                    imm_fmt_of = IMM_NONE;
        endcase
    endfunction

    // Everything the decode stage registers for one instruction
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  opcode;
        logic [2:0]  fun3;
        logic [6:0]  fun7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        is_alu;
        logic        is_lui;
        logic        is_auipc;
        logic        is_system;
        logic        is_mul;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/rv_imm_gen.sv
// rtl/rv_imm_gen.sv - combinational immediate extraction for the uRV decoder
module rv_imm_gen
    import rv_defs::*;
(
    input  logic [31:2] i_ir,
    output logic [31:0] o_imm
);

    imm_fmt_e w_fmt;

    assign w_fmt = imm_fmt_of(i_ir[6:2]);

    // Reassemble and sign-extend the immediate scattered in the chosen layout
    always_comb begin
        o_imm = '0;
        case (w_fmt)
            IMM_I:   o_imm = {{20{i_ir[31]}}, i_ir[31:20]};
            IMM_S:   o_imm = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
            IMM_B:   o_imm = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
            IMM_U:   o_imm = {i_ir[31:12], 12'b0};
            IMM_J:   o_imm = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/rv_decode.sv
// rtl/rv_decode.sv - uRV decode stage with load-use stall; RV_DECODE_MUL_EN enables M-extension decode
module rv_decode
    import rv_defs::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] f_ir_i,
    input  logic [31:0] f_pc_i,
    input  logic        f_valid_i,
    input  logic        d_stall_i,
    input  logic        d_kill_i,
    output logic        d_stall_req_o,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    output logic        d_valid_o,
    output logic [31:0] d_pc_o,
    output logic [4:0]  d_opcode_o,
    output logic [2:0]  d_fun3_o,
    output logic [6:0]  d_fun7_o,
    output logic [4:0]  d_rs1_o,
    output logic [4:0]  d_rs2_o,
    output logic [4:0]  d_rd_o,
    output logic [31:0] d_imm_o,
    output logic        d_is_load_o,
    output logic        d_is_store_o,
    output logic        d_is_branch_o,
    output logic        d_is_jal_o,
    output logic        d_is_jalr_o,
    output logic        d_is_alu_o,
    output logic        d_is_lui_o,
    output logic        d_is_auipc_o,
    output logic        d_is_system_o,
    output logic        d_is_mul_o,
    output logic        d_illegal_o
);

    dec_t        r_dec;
    logic        r_valid;

    dec_t        w_dec;
    logic [31:0] w_imm;
    logic [4:0]  w_opc;
    logic        w_known_opc;
    logic        w_mul_enc;
    logic        w_illegal;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_hazard;

    assign w_opc    = f_ir_i[6:2];
    assign rf_rs1_o = f_ir_i[19:15];
    assign rf_rs2_o = f_ir_i[24:20];

    rv_imm_gen u_imm_gen (
        .i_ir  (f_ir_i[31:2]),
        .o_imm (w_imm)
    );

    // Recognise the major opcodes and which source registers each one reads
    always_comb begin
        w_known_opc = 1'b0;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b0;
        case (w_opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: w_known_opc = 1'b1;
            OPC_STORE, OPC_OP, OPC_BRANCH: begin
                w_known_opc = 1'b1;
                w_uses_rs2  = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                w_known_opc = 1'b1;
                w_uses_rs1  = 1'b0;
            end
            default: w_known_opc = 1'b0;
        endcase
    end

    assign w_mul_enc = (w_opc == OPC_OP) && (f_ir_i[31:25] == FUN7_MULDIV);

`ifdef RV_DECODE_MUL_EN
    assign w_illegal = (f_ir_i[1:0] != 2'b11) || !w_known_opc;
`else
    assign w_illegal = (f_ir_i[1:0] != 2'b11) || !w_known_opc || w_mul_enc;
`endif

    // Build the full decode record of the incoming word; class flags stay clear when illegal
    always_comb begin
        w_dec         = '0;
        w_dec.pc      = f_pc_i;
        w_dec.opcode  = w_opc;
        w_dec.fun3    = f_ir_i[14:12];
        w_dec.fun7    = f_ir_i[31:25];
        w_dec.rs1     = f_ir_i[19:15];
        w_dec.rs2     = f_ir_i[24:20];
        w_dec.rd      = f_ir_i[11:7];
        w_dec.imm     = w_imm;
        w_dec.illegal = w_illegal;
        if (!w_illegal) begin
            case (w_opc)
                OPC_LOAD:   w_dec.is_load   = 1'b1;
                OPC_STORE:  w_dec.is_store  = 1'b1;
                OPC_BRANCH: w_dec.is_branch = 1'b1;
                OPC_JAL:    w_dec.is_jal    = 1'b1;
                OPC_JALR:   w_dec.is_jalr   = 1'b1;
                OPC_OP_IMM: w_dec.is_alu    = 1'b1;
                OPC_LUI:    w_dec.is_lui    = 1'b1;
                OPC_AUIPC:  w_dec.is_auipc  = 1'b1;
                OPC_SYSTEM: w_dec.is_system = 1'b1;
                OPC_OP: begin
                    if (w_mul_enc) w_dec.is_mul = 1'b1;
                    else           w_dec.is_alu = 1'b1;
                end
                default: w_dec.is_alu = 1'b0;
            endcase
        end
    end

    // The held load writes a register the incoming instruction reads; x0 never matches
    assign w_hazard = r_valid && r_dec.is_load && (r_dec.rd != 5'd0) &&
                      ((w_uses_rs1 && (f_ir_i[19:15] == r_dec.rd)) ||
                       (w_uses_rs2 && (f_ir_i[24:20] == r_dec.rd)));

    assign d_stall_req_o = f_valid_i && w_hazard && !d_kill_i;

    // Pipeline register: kill beats stall, stall holds, hazard inserts a bubble
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid <= 1'b0;
            r_dec   <= '0;
        end else if (d_kill_i) begin
            r_valid <= 1'b0;
        end else if (!d_stall_i) begin
            if (d_stall_req_o) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= f_valid_i;
                r_dec   <= w_dec;
            end
        end
    end

    assign d_valid_o     = r_valid;
    assign d_pc_o        = r_dec.pc;
    assign d_opcode_o    = r_dec.opcode;
    assign d_fun3_o      = r_dec.fun3;
    assign d_fun7_o      = r_dec.fun7;
    assign d_rs1_o       = r_dec.rs1;
    assign d_rs2_o       = r_dec.rs2;
    assign d_rd_o        = r_dec.rd;
    assign d_imm_o       = r_dec.imm;
    assign d_is_load_o   = r_dec.is_load;
    assign d_is_store_o  = r_dec.is_store;
    assign d_is_branch_o = r_dec.is_branch;
    assign d_is_jal_o    = r_dec.is_jal;
    assign d_is_jalr_o   = r_dec.is_jalr;
    assign d_is_alu_o    = r_dec.is_alu;
    assign d_is_lui_o    = r_dec.is_lui;
    assign d_is_auipc_o  = r_dec.is_auipc;
    assign d_is_system_o = r_dec.is_system;
    assign d_is_mul_o    = r_dec.is_mul;
    assign d_illegal_o   = r_dec.illegal;

endmodule

// File: tb/tb_rv_decode.sv
// tb/tb_rv_decode.sv - self-checking bench for rv_decode (honours RV_DECODE_MUL_EN)
module tb_rv_decode;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] f_ir_i = '0;
    logic [31:0] f_pc_i = '0;
    logic        f_valid_i = 1'b0;
    logic        d_stall_i = 1'b0;
    logic        d_kill_i = 1'b0;
    logic        d_stall_req_o;
    logic [4:0]  rf_rs1_o, rf_rs2_o;
    logic        d_valid_o;
    logic [31:0] d_pc_o, d_imm_o;
    logic [4:0]  d_opcode_o, d_rs1_o, d_rs2_o, d_rd_o;
    logic [2:0]  d_fun3_o;
    logic [6:0]  d_fun7_o;
    logic        d_is_load_o, d_is_store_o, d_is_branch_o, d_is_jal_o, d_is_jalr_o;
    logic        d_is_alu_o, d_is_lui_o, d_is_auipc_o, d_is_system_o, d_is_mul_o, d_illegal_o;

    rv_decode dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .f_ir_i(f_ir_i), .f_pc_i(f_pc_i),
        .f_valid_i(f_valid_i), .d_stall_i(d_stall_i), .d_kill_i(d_kill_i),
        .d_stall_req_o(d_stall_req_o), .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
        .d_valid_o(d_valid_o), .d_pc_o(d_pc_o), .d_opcode_o(d_opcode_o),
        .d_fun3_o(d_fun3_o), .d_fun7_o(d_fun7_o), .d_rs1_o(d_rs1_o), .d_rs2_o(d_rs2_o),
        .d_rd_o(d_rd_o), .d_imm_o(d_imm_o), .d_is_load_o(d_is_load_o),
        .d_is_store_o(d_is_store_o), .d_is_branch_o(d_is_branch_o), .d_is_jal_o(d_is_jal_o),
        .d_is_jalr_o(d_is_jalr_o), .d_is_alu_o(d_is_alu_o), .d_is_lui_o(d_is_lui_o),
        .d_is_auipc_o(d_is_auipc_o), .d_is_system_o(d_is_system_o), .d_is_mul_o(d_is_mul_o),
        .d_illegal_o(d_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // Flag order: load store branch jal jalr alu lui auipc system mul
    logic [9:0] d_fl;
    assign d_fl = {d_is_load_o, d_is_store_o, d_is_branch_o, d_is_jal_o, d_is_jalr_o,
                   d_is_alu_o, d_is_lui_o, d_is_auipc_o, d_is_system_o, d_is_mul_o};

    localparam logic [4:0] LD = 5'h00, OPI = 5'h04, AUI = 5'h05, ST = 5'h08, OPR = 5'h0C;
    localparam logic [4:0] LU = 5'h0D, BR = 5'h18, JLR = 5'h19, JL = 5'h1B, SYS = 5'h1C;
`ifdef RV_DECODE_MUL_EN
    localparam logic MUL_ON = 1'b1;
`else
    localparam logic MUL_ON = 1'b0;
`endif
    localparam logic [31:0] ADDI = 32'h00500093, LW_X2 = 32'h0000A103, ADD_X2 = 32'h002101B3;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc, imm;
        logic [4:0]  opc, rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [9:0]  fl;
        logic        ill;
    } mdec_t;

    typedef struct {
        logic [31:0] ir;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [9:0]  fl;
        logic        ill;
    } vec_t;

    mdec_t m_dec;
    logic  m_valid = 1'b0;
    vec_t  tv[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    // Reference decode computed arithmetically from the encoding rules
    function automatic mdec_t ref_decode(input logic [31:0] ir, input logic [31:0] pc);
        mdec_t  r;
        longint v;
        logic [4:0] op;
        op    = ir[6:2];
        r.pc  = pc;
        r.opc = op;
        r.rs1 = ir[19:15];
        r.rs2 = ir[24:20];
        r.rd  = ir[11:7];
        r.f3  = ir[14:12];
        r.f7  = ir[31:25];
        r.fl  = '0;
        r.ill = (ir[1:0] != 2'b11) || !(op inside {LD, OPI, AUI, ST, OPR, LU, BR, JLR, JL, SYS});
        if (!MUL_ON && op == OPR && ir[31:25] == 7'd1) r.ill = 1'b1;
        case (op)
            LD, OPI, JLR, SYS: v = longint'(ir[31:20]) - (ir[31] ? 4096 : 0);
            ST:     v = longint'(ir[31:25]) * 32 + longint'(ir[11:7]) - (ir[31] ? 4096 : 0);
            BR:     v = longint'(ir[7]) * 2048 + longint'(ir[30:25]) * 32 +
                        longint'(ir[11:8]) * 2 - (ir[31] ? 4096 : 0);
            LU, AUI: v = longint'(ir[31:12]) * 4096;
            JL:     v = longint'(ir[19:12]) * 4096 + longint'(ir[20]) * 2048 +
                        longint'(ir[30:21]) * 2 - (ir[31] ? 1048576 : 0);
            default: v = 0;
        endcase
        r.imm = v[31:0];
        if (!r.ill) begin
            case (op)
                LD:  r.fl[9] = 1'b1;
                ST:  r.fl[8] = 1'b1;
                BR:  r.fl[7] = 1'b1;
                JL:  r.fl[6] = 1'b1;
                JLR: r.fl[5] = 1'b1;
                OPI: r.fl[4] = 1'b1;
                LU:  r.fl[3] = 1'b1;
                AUI: r.fl[2] = 1'b1;
                SYS: r.fl[1] = 1'b1;
                OPR: if (ir[31:25] == 7'd1) r.fl[0] = 1'b1; else r.fl[4] = 1'b1;
                default: r.fl = '0;
            endcase
        end
        return r;
    endfunction

    function automatic logic model_sreq();
        logic [4:0] op;
        logic u1, u2;
        op = f_ir_i[6:2];
        u1 = !(op inside {LU, AUI, JL});
        u2 = op inside {OPR, ST, BR};
        return f_valid_i && m_valid && m_dec.fl[9] && (m_dec.rd != 5'd0) && !d_kill_i &&
               ((u1 && f_ir_i[19:15] == m_dec.rd) || (u2 && f_ir_i[24:20] == m_dec.rd));
    endfunction

    task automatic check_model(input logic sreq);
        chk("stall_req", d_stall_req_o, sreq);
        chk("rf_rs1", rf_rs1_o, f_ir_i[19:15]);
        chk("rf_rs2", rf_rs2_o, f_ir_i[24:20]);
        chk("valid", d_valid_o, m_valid);
        if (m_valid) begin
            chk("pc", d_pc_o, m_dec.pc);
            chk("fields", {d_opcode_o, d_fun3_o, d_fun7_o, d_rs1_o, d_rs2_o, d_rd_o},
                {m_dec.opc, m_dec.f3, m_dec.f7, m_dec.rs1, m_dec.rs2, m_dec.rd});
            chk("flags", {d_fl, d_illegal_o}, {m_dec.fl, m_dec.ill});
            if (!m_dec.ill) chk("imm", d_imm_o, m_dec.imm);
        end
    endtask

    // One clock: drive, check against the model, advance the model, cross the edge
    task automatic cycle(input logic [31:0] ir, input logic [31:0] pc,
                         input logic v, input logic st, input logic kl);
        logic sreq;
        f_ir_i = ir; f_pc_i = pc; f_valid_i = v; d_stall_i = st; d_kill_i = kl;
        #1;
        sreq = model_sreq();
        check_model(sreq);
        if (kl) m_valid = 1'b0;
        else if (!st) begin
            if (sreq) m_valid = 1'b0;
            else begin
                m_dec   = ref_decode(ir, pc);
                m_valid = v;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] ir;
        logic [4:0] ops[10] = '{LD, OPI, AUI, ST, OPR, LU, BR, JLR, JL, SYS};
        ir = $urandom;
        ir[6:0]   = {ops[$urandom_range(0, 9)], 2'b11};
        if ($urandom_range(0, 15) == 0) ir[1:0] = 2'(ir[9:8]);
        ir[11:7]  = 5'($urandom_range(0, 3));
        ir[19:15] = 5'($urandom_range(0, 3));
        ir[24:20] = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) ir[31:25] = 7'd1;
        return ir;
    endfunction

    initial begin
        tv[0]  = '{32'h00500093, 5'd1,  5'd0,  5'd5,  32'd5,        10'b0000010000, 1'b0};
        tv[1]  = '{32'hFE000EE3, 5'd29, 5'd0,  5'd0,  32'hFFFFFFFC, 10'b0010000000, 1'b0};
        tv[2]  = '{32'hFFFFFFFF, 5'd31, 5'd31, 5'd31, 32'd0,        10'b0000000000, 1'b1};
        tv[3]  = '{32'h027302B3, 5'd5,  5'd6,  5'd7,  32'd0,        {9'b0, MUL_ON},  !MUL_ON};
        tv[4]  = '{32'h123452B7, 5'd5,  5'd8,  5'd3,  32'h12345000, 10'b0000001000, 1'b0};
        tv[5]  = '{32'h0020A423, 5'd8,  5'd1,  5'd2,  32'd8,        10'b0100000000, 1'b0};
        tv[6]  = '{32'hFF9FF0EF, 5'd1,  5'd31, 5'd25, 32'hFFFFFFF8, 10'b0001000000, 1'b0};
        tv[7]  = '{32'h00008067, 5'd0,  5'd1,  5'd0,  32'd0,        10'b0000100000, 1'b0};
        tv[8]  = '{32'hFFFFF197, 5'd3,  5'd31, 5'd31, 32'hFFFFF000, 10'b0000000100, 1'b0};
        tv[9]  = '{32'h00000073, 5'd0,  5'd0,  5'd0,  32'd0,        10'b0000000010, 1'b0};
        tv[10] = '{32'h00000001, 5'd0,  5'd0,  5'd0,  32'd0,        10'b0000000000, 1'b1};
        tv[11] = '{32'hFFC0A103, 5'd2,  5'd1,  5'd28, 32'hFFFFFFFC, 10'b1000000000, 1'b0};

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", d_valid_o, 0);
        chk("rst_pc", d_pc_o, 0);
        chk("rst_imm", d_imm_o, 0);
        chk("rst_flags", {d_fl, d_illegal_o}, 0);
        chk("rst_stall_req", d_stall_req_o, 0);
        rst_n_i = 1'b1;

        // Single-instruction decode table, each followed by an idle slot
        for (int i = 0; i < 12; i++) begin
            cycle(tv[i].ir, 32'h100 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
            chk($sformatf("tv%0d_valid", i), d_valid_o, 1);
            chk($sformatf("tv%0d_pc", i), d_pc_o, 32'h100 + 32'(4 * i));
            chk($sformatf("tv%0d_regs", i), {d_rd_o, d_rs1_o, d_rs2_o}, {tv[i].rd, tv[i].rs1, tv[i].rs2});
            chk($sformatf("tv%0d_flags", i), {d_fl, d_illegal_o}, {tv[i].fl, tv[i].ill});
            if (!tv[i].ill) chk($sformatf("tv%0d_imm", i), d_imm_o, tv[i].imm);
            cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        end

        // Load-use: one-cycle stall, bubble, then the dependent add
        cycle(LW_X2, 32'h200, 1'b1, 1'b0, 1'b0);
        f_ir_i = ADD_X2; f_valid_i = 1'b1; #1;
        chk("lu_req", d_stall_req_o, 1);
        cycle(ADD_X2, 32'h204, 1'b1, 1'b0, 1'b0);
        chk("lu_bubble", d_valid_o, 0);
        chk("lu_req_drop", d_stall_req_o, 0);
        cycle(ADD_X2, 32'h204, 1'b1, 1'b0, 1'b0);
        chk("lu_add_valid", d_valid_o, 1);
        chk("lu_add_regs", {d_rs1_o, d_rs2_o, d_rd_o}, {5'd2, 5'd2, 5'd3});

        // Load into x0 never stalls
        cycle(32'h00002003, 32'h208, 1'b1, 1'b0, 1'b0);
        f_ir_i = 32'h000001B3; #1;
        chk("x0_no_req", d_stall_req_o, 0);
        cycle(32'h000001B3, 32'h20C, 1'b1, 1'b0, 1'b0);
        chk("x0_add_valid", d_valid_o, 1);

        // Downstream stall holds outputs for 3 cycles, then kill during stall
        cycle(ADDI, 32'h100, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(tv[k + 4].ir, 32'h400 + 32'(4 * k), 1'b1, 1'b1, 1'b0);
            chk("stall_hold", {d_valid_o, d_pc_o, d_imm_o, d_rd_o, d_is_alu_o},
                {1'b1, 32'h100, 32'd5, 5'd1, 1'b1});
        end
        cycle(tv[8].ir, 32'h40C, 1'b1, 1'b1, 1'b1);
        chk("kill_in_stall", d_valid_o, 0);

        // Stall and hazard together: stall wins, request persists, then bubble
        cycle(LW_X2, 32'h300, 1'b1, 1'b0, 1'b0);
        f_ir_i = ADD_X2; d_stall_i = 1'b1; #1;
        chk("sh_req", d_stall_req_o, 1);
        cycle(ADD_X2, 32'h304, 1'b1, 1'b1, 1'b0);
        chk("sh_held_load", {d_valid_o, d_is_load_o, d_pc_o}, {1'b1, 1'b1, 32'h300});
        chk("sh_req_held", d_stall_req_o, 1);
        cycle(ADD_X2, 32'h304, 1'b1, 1'b0, 1'b0);
        chk("sh_bubble", d_valid_o, 0);
        cycle(ADD_X2, 32'h304, 1'b1, 1'b0, 1'b0);
        chk("sh_add", {d_valid_o, d_rd_o, d_pc_o}, {1'b1, 5'd3, 32'h304});

        // Asynchronous reset mid-operation
        #2 rst_n_i = 1'b0;
        #1;
        chk("async_rst_valid", d_valid_o, 0);
        chk("async_rst_pc", d_pc_o, 0);
        m_valid = 1'b0;
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_idle", d_valid_o, 0);
        cycle(ADDI, 32'h500, 1'b1, 1'b0, 1'b0);
        chk("post_rst_first", {d_valid_o, d_pc_o}, {1'b1, 32'h500});

        // Randomised traffic against the reference model
        for (int n = 0; n < 800; n++) begin
            cycle(rand_ir(), $urandom, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_decode.md
# rv_decode

Instruction decode stage of the uRV pipeline, directly downstream of the fetch stage. It registers the fetched instruction word and PC. It splits the word into register indices, function fields and a sign-extended immediate, and classifies it into instruction categories. It detects load-use hazards against the instruction it currently holds, requests a fetch stall, and inserts a bubble. Register-file read addresses are driven combinationally from the incoming word, so operand data arrives in the same cycle as the registered decode.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  sole clock, all state on rising edge
- rst_n_i  in  1  reset, asynchronous assert, active-low
- f_ir_i  in  32  instruction word from fetch
- f_pc_i  in  32  PC of f_ir_i
- f_valid_i  in  1  f_ir_i/f_pc_i valid
- d_stall_i  in  1  downstream (execute) stall; hold all outputs
- d_kill_i  in  1  flush (taken branch in execute)
- d_stall_req_o  out  1  load-use stall request to fetch (OR'd into fetch stall)
- rf_rs1_o, rf_rs2_o  out  5  register-file read addresses = f_ir_i[19:15], f_ir_i[24:20], combinational
- d_valid_o  out  1  decoded instruction valid
- d_pc_o  out  32  registered PC
- d_opcode_o  out  5  f_ir[6:2]
- d_fun3_o  out  3  f_ir[14:12]
- d_fun7_o  out  7  f_ir[31:25]
- d_rs1_o, d_rs2_o, d_rd_o  out  5  register indices
- d_imm_o  out  32  sign-extended immediate
- d_is_load_o, d_is_store_o, d_is_branch_o, d_is_jal_o, d_is_jalr_o, d_is_alu_o, d_is_lui_o, d_is_auipc_o, d_is_system_o  out  1  one-hot class flags
- d_is_mul_o  out  1  M-extension op (see Configuration)
- d_illegal_o  out  1  unrecognised opcode, or f_ir[1:0] != 2'b11

## Operation
- Load-use hazard (combinational): d_stall_req_o = f_valid_i & d_valid_o & d_is_load_o & (d_rd_o != 0) & ((uses_rs1(f_ir_i) & rs1==d_rd_o) | (uses_rs2(f_ir_i) & rs2==d_rd_o)) & !d_kill_i.
  - uses_rs1: all opcodes except LUI, AUIPC, JAL.
  - uses_rs2: OP, STORE, BRANCH.
- Register update priority, highest first:
  1. d_kill_i: d_valid_o<=0; other fields don't-care. Kill overrides d_stall_i.
  2. d_stall_i: hold every output register.
  3. d_stall_req_o: d_valid_o<=0 (bubble); fields don't-care. Fetch holds the dependent instruction, which re-presents next cycle.
  4. Otherwise: capture decode of f_ir_i/f_pc_i; d_valid_o<=f_valid_i.
- Immediate formats:
  - I: ir[31:20] sign-extended.
  - S: {ir[31:25],ir[11:7]} sign-extended.
  - B: {ir[31],ir[7],ir[30:25],ir[11:8],0} sign-extended.
  - U: {ir[31:12],12'b0}.
  - J: {ir[31],ir[19:12],ir[20],ir[30:21],0} sign-extended.
  - Others: 0.
- Class flags are zero when d_illegal_o=1. d_illegal_o is qualified only while d_valid_o=1.

## Timing
- Latency: 1 cycle, f_* accepted on edge N, d_* visible after edge N.
- Reset: every registered output is 0 (d_valid_o=0, d_pc_o=0, d_imm_o=0, all flags 0). Asynchronous mid-operation reset drops d_valid_o immediately. The first valid decode follows the first f_valid_i after release.
- A load-use stall lasts exactly one cycle, since the bubble clears the hazard. It repeats only if another load is captured.
- Stall and hazard together: stall wins. d_stall_req_o stays asserted while the held load still matches, so fetch remains stalled.
- x0 as load destination never stalls.

## Configuration
- RV_DECODE_MUL_EN defined: OP opcode with fun7=7'b0000001 is legal, d_is_mul_o=1, d_is_alu_o=0.
- RV_DECODE_MUL_EN undefined: same encoding gives d_illegal_o=1; d_is_mul_o tied 0.

## Structure
- Shared package rv_defs: opcode constants (OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM) and the immediate-format enumeration.
- One sub-module rv_imm_gen: combinational, takes the instruction word and returns the 32-bit immediate.

## Test plan
- Reset then f_ir_i=0x00500093 (addi x1,x0,5), f_pc_i=0x100, valid:
  - Next cycle d_valid_o=1, d_rd_o=1, d_rs1_o=0, d_imm_o=5, d_is_alu_o=1, d_pc_o=0x100.
- 0x0000A103 (lw x2,0(x1)) then 0x002101B3 (add x3,x2,x2):
  - d_stall_req_o=1 for one cycle, bubble d_valid_o=0.
  - Add decodes the following cycle with d_rs1_o=d_rs2_o=2.
- 0xFE000EE3 (beq x0,x0,-4): d_is_branch_o=1, d_imm_o=0xFFFFFFFC.
- d_stall_i=1 for 3 cycles with new f_ir_i applied: outputs unchanged. Assert d_kill_i during the stall: d_valid_o=0 next cycle.
- f_ir_i=0xFFFFFFFF: d_illegal_o=1, all class flags 0.
- 0x027302B3 (mul x5,x6,x7):
  - With RV_DECODE_MUL_EN: d_is_mul_o=1, d_illegal_o=0.
  - Without: d_illegal_o=1.
